// File: rtl/coherence_controller.sv
// coherence_controller: N-core MSI snoop controller arbitrating icache/dcache traffic onto one RAM port.
// Define CC_FORWARD_EN to forward a snooped M line straight to the requester during the writeback.
module coherence_controller #(
   parameter int CPUS = 2,
   parameter int WORD_W = 32,
   parameter int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [CPUS-1:0]        iREN,
   input  logic [CPUS*WORD_W-1:0] iaddr,
   output logic [CPUS-1:0]        iwait,
   output logic [CPUS*WORD_W-1:0] iload,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS*WORD_W-1:0] daddr,
   input  logic [CPUS*WORD_W-1:0] dstore,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS*WORD_W-1:0] dload,
   input  logic [CPUS-1:0]        cctrans,
   input  logic [CPUS-1:0]        ccwrite,
   output logic [CPUS-1:0]        ccwait,
   output logic [CPUS-1:0]        ccinv,
   output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [WORD_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore,
   input  logic [WORD_W-1:0]      ramload,
   input  logic                   ramwait
);
   localparam logic [2:0] IDLE = 3'd0, IFETCH = 3'd1, DWB = 3'd2, SNOOP = 3'd3,
                          RESP = 3'd4, C2C = 3'd5, DREAD = 3'd6;
   logic [2:0] state;
   logic [IDX_W-1:0] g, k, rr, nxt_rr;
   logic snp, inv, sn, done;
   logic [IDX_W:0] pw, pr, pi, ps, sel;
   logic [CPUS-1:0] sup;
   logic [WORD_W-1:0] ia, ga, gs, ks;

   // first set bit of v scanning upward from p with wrap; MSB flags a hit
   function automatic logic [IDX_W:0] pick(input logic [CPUS-1:0] v, input logic [IDX_W-1:0] p);
      pick = '0;
      for (int i = CPUS - 1; i >= 0; i--)
         if (v[(int'(p) + i) % CPUS]) pick = {1'b1, IDX_W'((int'(p) + i) % CPUS)};
   endfunction

   always_comb begin
      sup = ccwrite & dWEN;
      sup[g] = 1'b0;
   end

   assign pw = pick(dWEN, rr);
   assign pr = pick(dREN, rr);
   assign pi = pick(iREN, rr);
   assign ps = pick(sup, '0);
   assign sel = pw[IDX_W] ? pw : pr[IDX_W] ? pr : pi;
   assign sn = !pw[IDX_W] && pr[IDX_W] && cctrans[pr[IDX_W-1:0]];
   assign ia = iaddr[int'(g)*WORD_W +: WORD_W];
   assign ga = daddr[int'(g)*WORD_W +: WORD_W];
   assign gs = dstore[int'(g)*WORD_W +: WORD_W];
   assign ks = dstore[int'(k)*WORD_W +: WORD_W];
   assign nxt_rr = (int'(g) == CPUS - 1) ? '0 : g + 1'b1;
   assign done = !ramwait && !RST;

   always_ff @(posedge CLK)
      if (RST) begin
         state <= IDLE;
         g <= '0;
         k <= '0;
         rr <= '0;
         snp <= 1'b0;
         inv <= 1'b0;
      end else
         case (state)
            IDLE:
               if (sel[IDX_W]) begin
                  g <= sel[IDX_W-1:0];
                  snp <= sn;
                  inv <= ccwrite[sel[IDX_W-1:0]];
                  state <= pw[IDX_W] ? DWB : sn ? SNOOP : pr[IDX_W] ? DREAD : IFETCH;
               end
            IFETCH, DWB, DREAD:
               if (!ramwait) begin
                  state <= IDLE;
                  rr <= nxt_rr;
                  snp <= 1'b0;
               end
            SNOOP: state <= RESP;
            RESP: begin
               k <= ps[IDX_W-1:0];
               state <= ps[IDX_W] ? C2C : DREAD;
            end
            C2C:
               if (!ramwait) begin
`ifdef CC_FORWARD_EN
                  state <= IDLE;
                  rr <= nxt_rr;
                  snp <= 1'b0;
`else
                  state <= DREAD;
`endif
               end
            default: state <= IDLE;
         endcase

   always_comb begin
      iwait = '1;
      dwait = '1;
      iload = '0;
      dload = '0;
      ccwait = '0;
      ccinv = '0;
      ccsnoopaddr = '0;
      ramREN = !RST && (state == IFETCH || state == DREAD);
      ramWEN = !RST && (state == DWB || state == C2C);
      ramaddr = (state == IFETCH) ? ia : (state == DWB || state == C2C || state == DREAD) ? ga : '0;
      ramstore = (state == DWB) ? gs : (state == C2C) ? ks : '0;
      if (done && state == IFETCH) begin
         iwait[g] = 1'b0;
         iload[int'(g)*WORD_W +: WORD_W] = ramload;
      end
      if (done && state == DWB) dwait[g] = 1'b0;
      if (done && state == DREAD) begin
         dwait[g] = 1'b0;
         dload[int'(g)*WORD_W +: WORD_W] = ramload;
      end
      if (done && state == C2C) begin
         dwait[k] = 1'b0;
`ifdef CC_FORWARD_EN
         dwait[g] = 1'b0;
         dload[int'(g)*WORD_W +: WORD_W] = ks;
`endif
      end
      for (int i = 0; i < CPUS; i++) begin
         ccwait[i] = snp && (i != int'(g));
         ccinv[i] = ccwait[i] && inv;
         if (ccwait[i]) ccsnoopaddr[i*WORD_W +: WORD_W] = ga;
      end
   end
endmodule

// File: tb/tb_coherence_controller.sv
// tb_coherence_controller: table vectors, corner-case sequences and randomized rounds against a RAM/arbitration model.
module tb_coherence_controller;
   localparam int CPUS = 2, W = 32;
   logic CLK = 1'b0, RST;
   logic [CPUS-1:0] iREN, dREN, dWEN, cctrans, ccwrite;
   logic [CPUS*W-1:0] iaddr, daddr, dstore;
   logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
   logic [CPUS*W-1:0] iload, dload, ccsnoopaddr;
   logic ramREN, ramWEN, ramwait;
   logic [W-1:0] ramaddr, ramstore, ramload;
   int passed = 0, total = 0;
   int lat = 0, cnt = 0, acc = 0, wrs = 0;
   logic [W-1:0] mem [0:1023];
   logic [W-1:0] exp_mem [0:1023];
   bit ram_ready = 1'b0;

   typedef struct {
      int cpu;
      int kind;
      logic [31:0] addr;
      logic [31:0] data;
      int lat;
      logic [31:0] exp;
      int cyc;
   } vec_t;
   vec_t tbl [7];

   coherence_controller #(.CPUS(CPUS), .WORD_W(W)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait));

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] base(input int i);
      return {16'hC0DE, 16'(i)};
   endfunction

   // RAM with programmable wait: ramwait stays high for lat cycles of each access
   assign ramwait = (ramREN | ramWEN) && cnt < lat;
   assign ramload = ramREN ? mem[ramaddr[11:2]] : '0;
   always @(posedge CLK) begin
      if (!ram_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= base(i);
         ram_ready <= 1'b1;
      end else if ((ramREN | ramWEN) && !ramwait) begin
         acc <= acc + 1;
         cnt <= 0;
         if (ramWEN) begin
            mem[ramaddr[11:2]] <= ramstore;
            wrs <= wrs + 1;
         end
      end else
         cnt <= (ramREN | ramWEN) ? cnt + 1 : 0;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic idle_all;
      iREN = '0;
      dREN = '0;
      dWEN = '0;
      cctrans = '0;
      ccwrite = '0;
   endtask

   task automatic do_reset;
      RST = 1'b1;
      idle_all();
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int c, n, got, ew, ek, k, m_rr, a0, w0;
      int ia[CPUS], da[CPUS];
      bit fin, oth, slf, sup, held;
      logic [31:0] data, expd;
      tbl[0] = '{0, 0, 32'h100, 32'h0, 0, 32'hC0DE0040, 1};
      tbl[1] = '{1, 0, 32'h200, 32'h0, 1, 32'hC0DE0080, 2};
      tbl[2] = '{1, 1, 32'h300, 32'h0, 0, 32'hC0DE00C0, 1};
      tbl[3] = '{0, 2, 32'h3F0, 32'hA5A5F00D, 2, 32'hA5A5F00D, 3};
      tbl[4] = '{1, 1, 32'h3F0, 32'h0, 0, 32'hA5A5F00D, 1};
      tbl[5] = '{0, 3, 32'h10, 32'h0, 0, 32'hC0DE0004, 3};
      tbl[6] = '{1, 3, 32'h14, 32'h0, 2, 32'hC0DE0005, 5};
      for (int i = 0; i < 1024; i++) exp_mem[i] = base(i);
      iaddr = '0;
      daddr = '0;
      dstore = '0;
      // reset with every request high
      RST = 1'b1;
      iREN = '1;
      dREN = '1;
      dWEN = '1;
      cctrans = '0;
      ccwrite = '0;
      daddr[0 +: W] = 32'h3FC;
      dstore[0 +: W] = 32'h11110000;
      tick();
      tick();
      check("rst_iwait", 32'(iwait), 32'h3);
      check("rst_dwait", 32'(dwait), 32'h3);
      check("rst_ccwait", 32'(ccwait), 32'h0);
      check("rst_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
      check("rst_ramaddr", ramaddr, 32'h0);
      RST = 1'b0;
      tick();
      check("first_grant_dwait", 32'(dwait), 32'h2);
      check("first_grant_addr", ramaddr, 32'h3FC);
      exp_mem[255] = 32'h11110000;
      idle_all();
      tick();
      // single-transaction table
      for (int v = 0; v < 7; v++) begin
         lat = tbl[v].lat;
         c = tbl[v].cpu;
         if (tbl[v].kind == 0) begin
            iREN[c] = 1'b1;
            iaddr[c*W +: W] = tbl[v].addr;
         end else begin
            daddr[c*W +: W] = tbl[v].addr;
            dstore[c*W +: W] = tbl[v].data;
            dWEN[c] = tbl[v].kind == 2;
            dREN[c] = tbl[v].kind != 2;
            cctrans[c] = tbl[v].kind == 3;
            ccwrite[c] = tbl[v].kind == 3;
         end
         n = 0;
         fin = 1'b0;
         oth = 1'b0;
         slf = 1'b0;
         data = '0;
         while (!fin && n < 20) begin
            tick();
            n++;
            if (ccwait[1-c] && ccinv[1-c] && ccsnoopaddr[(1-c)*W +: W] == tbl[v].addr) oth = 1'b1;
            if (ccwait[c] || ccinv[c]) slf = 1'b1;
            if (tbl[v].kind == 0 ? !iwait[c] : !dwait[c]) begin
               fin = 1'b1;
               data = tbl[v].kind == 0 ? iload[c*W +: W] : dload[c*W +: W];
            end
         end
         check($sformatf("vec%0d_cycles", v), n, tbl[v].cyc);
         check($sformatf("vec%0d_snoop_other", v), 32'(oth), 32'(tbl[v].kind == 3));
         check($sformatf("vec%0d_snoop_self", v), 32'(slf), 32'h0);
         idle_all();
         tick();
         if (tbl[v].kind == 2) begin
            check($sformatf("vec%0d_ram", v), mem[tbl[v].addr[11:2]], tbl[v].exp);
            exp_mem[tbl[v].addr[11:2]] = tbl[v].exp;
         end else
            check($sformatf("vec%0d_data", v), data, tbl[v].exp);
      end
      lat = 0;
      // round-robin between two icache fetches held high
      do_reset();
      iaddr[0 +: W] = 32'h100;
      iaddr[W +: W] = 32'h200;
      iREN = '1;
      k = 0;
      for (int t = 0; t < 12 && k < 4; t++) begin
         tick();
         if (iwait != 2'b11) begin
            c = iwait[0] ? 1 : 0;
            check($sformatf("rr_grant%0d", k), c, k % 2);
            check($sformatf("rr_data%0d", k), iload[c*W +: W], c == 1 ? 32'hC0DE0080 : 32'hC0DE0040);
            k++;
         end
      end
      check("rr_count", k, 4);
      idle_all();
      tick();
      // writeback beats a fetch regardless of pointer
      dWEN[1] = 1'b1;
      daddr[W +: W] = 32'h40;
      dstore[W +: W] = 32'hDEADBEEF;
      iREN[0] = 1'b1;
      iaddr[0 +: W] = 32'h100;
      tick();
      check("prio_dwait", 32'(dwait), 32'h1);
      check("prio_iwait", 32'(iwait), 32'h3);
      check("prio_ramwen", 32'(ramWEN), 32'h1);
      dWEN[1] = 1'b0;
      tick();
      check("prio_ram", mem[16], 32'hDEADBEEF);
      exp_mem[16] = 32'hDEADBEEF;
      tick();
      check("prio_fetch_iwait", 32'(iwait), 32'h2);
      check("prio_fetch_data", iload[0 +: W], 32'hC0DE0040);
      idle_all();
      tick();
      // snoop invalidate, no M supplier
      dREN[0] = 1'b1;
      cctrans[0] = 1'b1;
      ccwrite[0] = 1'b1;
      daddr[0 +: W] = 32'h80;
      tick();
      check("snp_ccwait", 32'(ccwait), 32'h2);
      check("snp_ccinv", 32'(ccinv), 32'h2);
      check("snp_addr1", ccsnoopaddr[W +: W], 32'h80);
      check("snp_addr0", ccsnoopaddr[0 +: W], 32'h0);
      tick();
      tick();
      check("snp_dwait", 32'(dwait), 32'h2);
      check("snp_data", dload[0 +: W], 32'hC0DE0020);
      check("snp_ccwait_hold", 32'(ccwait), 32'h2);
      idle_all();
      tick();
      check("snp_ccwait_idle", 32'(ccwait), 32'h0);
      check("snp_ccinv_idle", 32'(ccinv), 32'h0);
      // cache-to-cache: core1 holds the line in M
      a0 = acc;
      dREN[0] = 1'b1;
      cctrans[0] = 1'b1;
      ccwrite[0] = 1'b1;
      daddr[0 +: W] = 32'h80;
      tick();
      ccwrite[1] = 1'b1;
      dWEN[1] = 1'b1;
      daddr[W +: W] = 32'h80;
      dstore[W +: W] = 32'h12345678;
      n = 0;
      fin = 1'b0;
      sup = 1'b0;
      data = '0;
      while (!fin && n < 10) begin
         tick();
         n++;
         if (!dwait[1]) begin
            sup = 1'b1;
            dWEN[1] = 1'b0;
            ccwrite[1] = 1'b0;
         end
         if (!dwait[0]) begin
            fin = 1'b1;
            data = dload[0 +: W];
         end
      end
      idle_all();
      tick();
      check("c2c_supplier_ack", 32'(sup), 32'h1);
      check("c2c_data", data, 32'h12345678);
      check("c2c_ram", mem[32], 32'h12345678);
`ifdef CC_FORWARD_EN
      check("c2c_ram_accesses", acc - a0, 1);
`else
      check("c2c_ram_accesses", acc - a0, 2);
`endif
      exp_mem[32] = 32'h12345678;
      // RAM latency of 3 cycles
      lat = 3;
      dREN[0] = 1'b1;
      daddr[0 +: W] = 32'h300;
      held = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         if (!dwait[0]) held = 1'b0;
      end
      check("lat_dwait_held", 32'(held), 32'h1);
      tick();
      check("lat_dwait_drop", 32'(dwait), 32'h2);
      check("lat_data", dload[0 +: W], 32'hC0DE00C0);
      idle_all();
      tick();
      lat = 0;
      // reset while snooping
      w0 = wrs;
      dREN[0] = 1'b1;
      cctrans[0] = 1'b1;
      ccwrite[0] = 1'b1;
      daddr[0 +: W] = 32'h80;
      tick();
      dWEN[1] = 1'b1;
      ccwrite[1] = 1'b1;
      daddr[W +: W] = 32'h80;
      dstore[W +: W] = 32'hBAD0BAD0;
      RST = 1'b1;
      tick();
      check("rstmid_ccwait", 32'(ccwait), 32'h0);
      check("rstmid_ccinv", 32'(ccinv), 32'h0);
      check("rstmid_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
      check("rstmid_dwait", 32'(dwait), 32'h3);
      idle_all();
      tick();
      RST = 1'b0;
      tick();
      check("rstmid_no_write", wrs - w0, 0);
      check("rstmid_ram", mem[32], 32'h12345678);
      // randomized rounds against the arbitration/RAM model
      do_reset();
      m_rr = 0;
      for (int r = 0; r < 60; r++) begin
         lat = $urandom_range(0, 2);
         for (int i = 0; i < CPUS; i++) begin
            ia[i] = $urandom_range(0, 1023);
            da[i] = $urandom_range(0, 1023);
            iaddr[i*W +: W] = 32'(ia[i] * 4);
            daddr[i*W +: W] = 32'(da[i] * 4);
            dstore[i*W +: W] = $urandom;
            iREN[i] = 1'($urandom_range(0, 1));
            dREN[i] = 1'($urandom_range(0, 1));
            dWEN[i] = 1'($urandom_range(0, 1));
            cctrans[i] = 1'($urandom_range(0, 1));
            ccwrite[i] = 1'($urandom_range(0, 1));
         end
         if (!(|{iREN, dREN, dWEN})) iREN[0] = 1'b1;
         ew = -1;
         ek = 0;
         for (int cls = 3; cls >= 1; cls--)
            for (int off = 0; off < CPUS; off++) begin
               c = (m_rr + off) % CPUS;
               if (ew < 0 && (cls == 3 ? dWEN[c] : cls == 2 ? dREN[c] : iREN[c])) begin
                  ew = c;
                  ek = cls;
               end
            end
         expd = ek == 1 ? exp_mem[ia[ew]] : ek == 2 ? exp_mem[da[ew]] : dstore[ew*W +: W];
         n = 0;
         got = -1;
         data = '0;
         while (got < 0 && n < 20) begin
            tick();
            n++;
            for (int i = 0; i < CPUS; i++)
               if (got < 0 && !dwait[i]) begin
                  got = i * 4 + (ramWEN ? 3 : 2);
                  data = dload[i*W +: W];
               end else if (got < 0 && !iwait[i]) begin
                  got = i * 4 + 1;
                  data = iload[i*W +: W];
               end
         end
         check($sformatf("rnd%0d_grant", r), got, ew * 4 + ek);
         idle_all();
         tick();
         if (ek == 3) begin
            exp_mem[da[ew]] = expd;
            check($sformatf("rnd%0d_ram", r), mem[da[ew]], expd);
         end else
            check($sformatf("rnd%0d_data", r), data, expd);
         m_rr = (ew + 1) % CPUS;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
